mem_arbiter: RTL and testbench

Arbitrates the processor's single external memory port between the instruction fetch unit and the load/store path of the execution unit. Each requester gets a request/grant/response handshake. One transaction at a time owns `ext_addr`, `ext_data_out` and `ext_mem_en`, with completion signalled by `ext_ready`. Sits between the IFU/EXU and the top-level memory pins. It replaces the permanent `ext_mem_en = ~reset` tie-off with sequenced, watchdog-protected accesses.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arb_watchdog.sv | 41 ++++
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and default sizing for the external memory
//                port arbiter and its watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Arbiter FSM: waiting for a request, or one transaction owns the port
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    // Which requester owns the transaction currently on the port
    typedef enum logic [0:0] {
        OWN_FETCH = 1'b0,
        OWN_LS    = 1'b1
    } arb_owner_t;

    localparam int c_DEF_ADDR_W       = 32;
    localparam int c_DEF_DATA_W       = 32;
    localparam int c_DEF_STARVE_LIMIT = 4;
    localparam int c_DEF_TIMEOUT      = 255;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_watchdog
//  Description : Counts enabled cycles since the last clear and flags the
//                TIMEOUT-th enabled cycle. Usable by any bus master that
//                needs a bounded wait on a slave handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = c_DEF_TIMEOUT
)(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // Count value present during the TIMEOUT-th enabled cycle
    localparam logic [CW-1:0] c_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // Cycle counter: cleared by the owner, saturates on the final cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_LAST)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign expired = enable && (r_count == c_LAST);

endmodule : mem_arb_watchdog
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares the single external memory port between instruction
//                fetch and load/store. One transaction at a time, load/store
//                preferred, with a starvation bound for fetch and a watchdog
//                abort when memory never answers. All outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = c_DEF_ADDR_W,
    parameter int DATA_W       = c_DEF_DATA_W,
    parameter int STARVE_LIMIT = c_DEF_STARVE_LIMIT,
    parameter int TIMEOUT      = c_DEF_TIMEOUT
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_data_out,
    output logic              ext_we,
    output logic              ext_mem_en,
    input  logic [DATA_W-1:0] ext_data_in,
    input  logic              ext_ready,
    output logic              busy
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] c_STREAK_MAX = SW'(STARVE_LIMIT);

    arb_state_t        r_state, w_state_nxt;
    arb_owner_t        r_owner, w_owner_nxt;
    logic [SW-1:0]     r_streak, w_streak_nxt;
    logic              w_grant, w_done, w_abort, w_finish;
    logic              w_wd_expired;
    logic [DATA_W-1:0] w_rdata;

    logic              r_if_gnt, r_if_rvalid, r_if_err;
    logic              r_ls_gnt, r_ls_rvalid, r_ls_err;
    logic [DATA_W-1:0] r_if_rdata, r_ls_rdata;
    logic [ADDR_W-1:0] r_ext_addr;
    logic [DATA_W-1:0] r_ext_data_out;
    logic              r_ext_we, r_ext_mem_en;

    // Watchdog runs only while a transaction owns the port
    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (r_state == IDLE),
        .enable  (r_state == ACCESS),
        .expired (w_wd_expired)
    );

    // Next state, owner selection and starvation streak
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_streak_nxt = r_streak;
        w_grant      = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!if_req) begin
                    w_streak_nxt = '0;
                end
                if (if_req || ls_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ACCESS;
                    if (if_req && (!ls_req || (r_streak == c_STREAK_MAX))) begin
                        w_owner_nxt  = OWN_FETCH;
                        w_streak_nxt = '0;
                    end else begin
                        w_owner_nxt = OWN_LS;
                        if (if_req && (r_streak != c_STREAK_MAX)) begin
                            w_streak_nxt = r_streak + SW'(1);
                        end
                    end
                end
            end
            ACCESS: begin
                // A ready on the final watchdog cycle still wins
                if (ext_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_wd_expired) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_finish = w_done || w_abort;
    // Stores and aborted accesses return zero data
    assign w_rdata  = (w_done && !r_ext_we) ? ext_data_in : '0;

    // State, handshake pulses and the external port registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_owner        <= OWN_FETCH;
            r_streak       <= '0;
            r_if_gnt       <= 1'b0;
            r_if_rvalid    <= 1'b0;
            r_if_err       <= 1'b0;
            r_if_rdata     <= '0;
            r_ls_gnt       <= 1'b0;
            r_ls_rvalid    <= 1'b0;
            r_ls_err       <= 1'b0;
            r_ls_rdata     <= '0;
            r_ext_addr     <= '0;
            r_ext_data_out <= '0;
            r_ext_we       <= 1'b0;
            r_ext_mem_en   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_streak    <= w_streak_nxt;
            r_if_gnt    <= w_grant && (w_owner_nxt == OWN_FETCH);
            r_ls_gnt    <= w_grant && (w_owner_nxt == OWN_LS);
            r_if_rvalid <= w_finish && (r_owner == OWN_FETCH);
            r_ls_rvalid <= w_finish && (r_owner == OWN_LS);
            r_if_err    <= w_abort && (r_owner == OWN_FETCH);
            r_ls_err    <= w_abort && (r_owner == OWN_LS);
            if (w_grant) begin
                r_ext_mem_en <= 1'b1;
                if (w_owner_nxt == OWN_FETCH) begin
                    r_ext_addr     <= if_addr;
                    r_ext_data_out <= '0;
                    r_ext_we       <= 1'b0;
                end else begin
                    r_ext_addr     <= ls_addr;
                    r_ext_data_out <= ls_wdata;
                    r_ext_we       <= ls_we;
                end
            end else if (w_finish) begin
                r_ext_mem_en <= 1'b0;
                r_ext_we     <= 1'b0;
            end
            if (w_finish) begin
                if (r_owner == OWN_FETCH) begin
                    r_if_rdata <= w_rdata;
                end else begin
                    r_ls_rdata <= w_rdata;
                end
            end
        end
    end

    assign if_gnt       = r_if_gnt;
    assign if_rvalid    = r_if_rvalid;
    assign if_rdata     = r_if_rdata;
    assign if_err       = r_if_err;
    assign ls_gnt       = r_ls_gnt;
    assign ls_rvalid    = r_ls_rvalid;
    assign ls_rdata     = r_ls_rdata;
    assign ls_err       = r_ls_err;
    assign ext_addr     = r_ext_addr;
    assign ext_data_out = r_ext_data_out;
    assign ext_we       = r_ext_we;
    assign ext_mem_en   = r_ext_mem_en;
    assign busy         = (r_state == ACCESS);

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter: directed scenarios plus
//                randomized requesters and memory, compared each cycle with a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int STARVE  = 4;
    localparam int TIMEOUT = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid, if_err;
    logic [DW-1:0] if_rdata;
    logic          ls_req = 1'b0, ls_we = 1'b0;
    logic [AW-1:0] ls_addr = '0;
    logic [DW-1:0] ls_wdata = '0;
    logic          ls_gnt, ls_rvalid, ls_err;
    logic [DW-1:0] ls_rdata;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_data_out;
    logic          ext_we, ext_mem_en, busy;
    logic [DW-1:0] ext_data_in = '0;
    logic          ext_ready = 1'b0;

    mem_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (STARVE),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_gnt       (if_gnt),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .if_err       (if_err),
        .ls_req       (ls_req),
        .ls_we        (ls_we),
        .ls_addr      (ls_addr),
        .ls_wdata     (ls_wdata),
        .ls_gnt       (ls_gnt),
        .ls_rvalid    (ls_rvalid),
        .ls_rdata     (ls_rdata),
        .ls_err       (ls_err),
        .ext_addr     (ext_addr),
        .ext_data_out (ext_data_out),
        .ext_we       (ext_we),
        .ext_mem_en   (ext_mem_en),
        .ext_data_in  (ext_data_in),
        .ext_ready    (ext_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Single comparison point: counts and reports
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit            m_busy = 0;     // a transaction owns the port
    bit            m_fetch = 0;    // owner is fetch
    bit            m_we = 0;
    int            m_age = 0;      // ACCESS cycles elapsed
    int            m_streak = 0;   // LS grants in a row while fetch waits
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    bit e_if_gnt, e_ls_gnt, e_if_rv, e_ls_rv, e_if_err, e_ls_err, e_rst;
    logic [DW-1:0] e_rdata;

    // Predict what the port looks like after the coming edge
    task automatic predict();
        bit fetch_turn;
        e_if_gnt = 0; e_ls_gnt = 0; e_if_rv = 0; e_ls_rv = 0;
        e_if_err = 0; e_ls_err = 0; e_rst = 0; e_rdata = '0;
        if (!reset) begin
            m_busy = 0; m_streak = 0; m_we = 0; m_addr = '0; m_wdata = '0;
            e_rst = 1;
            return;
        end
        if (m_busy) begin
            m_age++;
            if (ext_ready || m_age >= TIMEOUT) begin
                e_rdata = (ext_ready && !m_we) ? ext_data_in : '0;
                if (m_fetch) begin e_if_rv = 1; e_if_err = !ext_ready; end
                else         begin e_ls_rv = 1; e_ls_err = !ext_ready; end
                m_busy = 0;
                m_we   = 0;
            end
        end else begin
            fetch_turn = if_req && (!ls_req || m_streak >= STARVE);
            if (if_req || ls_req) begin
                m_busy  = 1;
                m_age   = 0;
                m_fetch = fetch_turn;
                if (fetch_turn) begin
                    e_if_gnt = 1; m_addr = if_addr; m_we = 0;
                end else begin
                    e_ls_gnt = 1; m_addr = ls_addr; m_we = ls_we; m_wdata = ls_wdata;
                end
            end
            if (fetch_turn || !if_req) m_streak = 0;
            else if (ls_req && m_streak < STARVE) m_streak++;
        end
    endtask

    task automatic compare();
        check_val("if_gnt",     if_gnt,     e_if_gnt);
        check_val("ls_gnt",     ls_gnt,     e_ls_gnt);
        check_val("if_rvalid",  if_rvalid,  e_if_rv);
        check_val("ls_rvalid",  ls_rvalid,  e_ls_rv);
        check_val("ext_mem_en", ext_mem_en, m_busy);
        check_val("busy",       busy,       m_busy);
        check_val("ext_we",     ext_we,     m_we);
        if (e_if_rv) begin
            check_val("if_err",   if_err,   e_if_err);
            check_val("if_rdata", if_rdata, e_rdata);
        end
        if (e_ls_rv) begin
            check_val("ls_err",   ls_err,   e_ls_err);
            check_val("ls_rdata", ls_rdata, e_rdata);
        end
        if (m_busy || e_rst) check_val("ext_addr", ext_addr, m_addr);
        if ((m_busy && m_we) || e_rst) check_val("ext_data_out", ext_data_out, m_wdata);
        if (e_rst) begin
            check_val("rst_if_rdata", if_rdata, 0);
            check_val("rst_ls_rdata", ls_rdata, 0);
            check_val("rst_if_err",   if_err,   0);
            check_val("rst_ls_err",   ls_err,   0);
        end
    endtask

    // One clock: predict from current inputs, then sample after the edge
    task automatic tick();
        predict();
        @(posedge clk);
        #1;
        compare();
    endtask

    // ---------------- random requesters and memory ----------------
    bit if_out = 0, ls_out = 0;
    int p_if = 50, p_ls = 50, p_rdy = 50;
    int ls_run = 0;

    task automatic agents();
        if (if_req && if_gnt) begin if_req = 0; if_out = 1; end
        if (ls_req && ls_gnt) begin ls_req = 0; ls_out = 1; end
        if (if_rvalid) if_out = 0;
        if (ls_rvalid) ls_out = 0;
        if (!if_req && !if_out && $urandom_range(0, 99) < p_if) begin
            if_req  = 1;
            if_addr = $urandom;
        end
        if (!ls_req && !ls_out && $urandom_range(0, 99) < p_ls) begin
            ls_req   = 1;
            ls_we    = $urandom_range(0, 1) == 1;
            ls_addr  = $urandom;
            ls_wdata = $urandom;
        end
        ext_ready   = $urandom_range(0, 99) < p_rdy;
        ext_data_in = $urandom;
    endtask

    initial begin
        int cyc;
        int runs [2];
        int n_if;

        // Reset held: everything must read zero
        repeat (3) tick();
        reset = 1;
        tick();

        // Single fetch with immediate ready
        if_req = 1; if_addr = 32'h100;
        tick();
        check_val("fetch_gnt", if_gnt, 1);
        check_val("fetch_addr", ext_addr, 32'h100);
        if_req = 0; ext_ready = 1; ext_data_in = 32'hDEADBEEF;
        tick();
        ext_ready = 0;
        check_val("fetch_rvalid", if_rvalid, 1);
        check_val("fetch_rdata", if_rdata, 32'hDEADBEEF);
        check_val("fetch_err", if_err, 0);

        // Store: payload held on the port through ACCESS, zero read data
        ls_req = 1; ls_we = 1; ls_addr = 32'h2000; ls_wdata = 32'h12345678;
        tick();
        ls_req = 0; ls_we = 0; ext_data_in = 32'hFFFF0000;
        repeat (2) begin
            tick();
            check_val("store_we", ext_we, 1);
            check_val("store_dout", ext_data_out, 32'h12345678);
        end
        ext_ready = 1;
        tick();
        ext_ready = 0;
        check_val("store_rvalid", ls_rvalid, 1);
        check_val("store_rdata", ls_rdata, 0);

        // Timeout: no ready ever, abort exactly TIMEOUT cycles after grant
        ls_req = 1; ls_addr = 32'h3000;
        tick();
        ls_req = 0;
        cyc = 0;
        do begin tick(); cyc++; end while (!ls_rvalid && cyc < 3 * TIMEOUT);
        check_val("to_latency", cyc, TIMEOUT);
        check_val("to_err", ls_err, 1);
        check_val("to_rdata", ls_rdata, 0);
        check_val("to_mem_en", ext_mem_en, 0);

        // Ready on the final watchdog cycle is a success
        if_req = 1; if_addr = 32'h440;
        tick();
        if_req = 0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            ext_ready = (i == TIMEOUT);
            ext_data_in = 32'hA5A5_0000 + i;
            tick();
        end
        ext_ready = 0;
        check_val("edge_rvalid", if_rvalid, 1);
        check_val("edge_err", if_err, 0);

        // Reset during the second ACCESS cycle aborts silently
        if_req = 1; if_addr = 32'h500;
        tick();
        if_req = 0;
        tick();
        reset = 0;
        tick();
        reset = 1;
        for (int i = 0; i < 12; i++) begin
            ext_ready = $urandom_range(0, 1) == 1;
            tick();
        end
        ext_ready = 0;
        if_req = 1; if_addr = 32'h600;
        tick();
        if_req = 0; ext_ready = 1; ext_data_in = 32'h0BADF00D;
        tick();
        ext_ready = 0;
        check_val("post_rst_rdata", if_rdata, 32'h0BADF00D);

        // Simultaneous requests from idle, with a stray ready in IDLE
        ext_ready = 1;
        tick();
        ext_ready = 0;
        if_req = 1; if_addr = 32'h700; ls_req = 1; ls_we = 0; ls_addr = 32'h800;
        tick();
        check_val("sim_ls_first", ls_gnt, 1);
        ls_req = 0; ext_ready = 1;
        tick();
        ext_ready = 0;
        tick();
        check_val("sim_if_next", if_gnt, 1);
        if_req = 0; ext_ready = 1;
        tick();
        ext_ready = 0;
        tick();

        // Starvation: both hammer, memory always ready
        p_if = 100; p_ls = 100; p_rdy = 100;
        if_out = 0; ls_out = 0; n_if = 0; ls_run = 0; cyc = 0;
        while (n_if < 2 && cyc < 200) begin
            agents();
            tick();
            cyc++;
            if (ls_gnt) ls_run++;
            if (if_gnt) begin runs[n_if] = ls_run; ls_run = 0; n_if++; end
        end
        check_val("starve_done", n_if, 2);
        check_val("starve_run0", runs[0], STARVE);
        check_val("starve_run1", runs[1], STARVE);

        // Randomized traffic under different memory behaviours
        for (int ph = 0; ph < 3; ph++) begin
            p_if  = (ph == 2) ? 90 : 40;
            p_ls  = (ph == 2) ? 90 : 60;
            p_rdy = (ph == 0) ? 50 : ((ph == 1) ? 8 : 70);
            for (int i = 0; i < 700; i++) begin
                agents();
                if ($urandom_range(0, 999) == 0) begin
                    reset = 0; if_req = 0; ls_req = 0; if_out = 0; ls_out = 0;
                end
                tick();
                reset = 1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
